score_counter: RTL and testbench
================================

Name: score_counter

Overview:
- Game-score bookkeeping stage directly upstream of the on-screen text overlay.
- Accumulates hit/bonus events into a two-digit BCD score, tracks remaining balls, and drives game-over.
- Presents score digits (dig0 = ones, dig1 = tens) and ball count through frame-synchronous output registers, so the overlay never shows a value changing mid-frame.

Parameters:
MAX_BALLS, 3, balls at start of game (1..7)
SATURATE, 1, 1 = score holds at 99; 0 = score wraps 99 -> 00 and pulses ovf

Ports:
clk  input  1  system clock (pixel-domain clock shared with the overlay)
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse at start of vertical blanking
hit  input  1  one-cycle pulse: +1 point
bonus  input  1  one-cycle pulse: +5 points
miss  input  1  one-cycle pulse: ball lost
clear  input  1  synchronous new-game request
dig0  output  4  displayed ones digit, BCD
dig1  output  4  displayed tens digit, BCD
balls  output  3  displayed remaining balls
game_over  output  1  high while in OVER state
ovf  output  1  one-cycle pulse on wrap (SATURATE=0 only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0):
  - Working score w1:w0 = 00; working balls wb = MAX_BALLS; state = PLAY.
  - dig0 = 0, dig1 = 0, balls = MAX_BALLS, game_over = 0, ovf = 0.
- States:
  - PLAY: events honoured.
  - OVER: hit/bonus/miss ignored; only clear leaves it.
- Per-cycle priority:
  - clear > (hit/bonus, miss), evaluated in the same cycle.
  - clear: w1:w0 <= 00, wb <= MAX_BALLS, state <= PLAY. Display registers are not touched; they follow at the next frame_tick.
- Increment in PLAY:
  - inc = hit*1 + bonus*5 (0, 1, 5 or 6).
  - BCD add: ones digit sum > 9 -> subtract 10 and carry into the tens digit.
  - If the result exceeds 99:
    - SATURATE=1: result 99.
    - SATURATE=0: result mod 100, ovf high for exactly one cycle.
  - Working registers update one cycle after the event.
- Miss in PLAY:
  - wb <= wb - 1.
  - If wb == 1 before the decrement, state <= OVER in the same update.
  - Same-cycle hit/bonus is still scored, since the ball was lost after scoring.
  - wb never underflows: misses are ignored in OVER.
- Frame sync:
  - On a cycle with frame_tick = 1: dig0 <= w0, dig1 <= w1, balls <= wb, sampling the register values present at that edge.
  - An event coinciding with frame_tick therefore appears at the following tick.
  - Latency from event to display: 1 cycle + wait for next frame_tick + 1 cycle.
  - Without frame_tick, outputs hold indefinitely.
- game_over is registered from state, is not frame-synced, and asserts the cycle after the final miss.
- w0 and w1 are always legal BCD (0..9); no illegal code can be produced.
- Reset mid-frame: outputs return to reset values immediately, with no tick needed.

Decomposition:
- Package score_pkg holds:
  - state enum {PLAY, OVER};
  - BCD_MAX_DIGIT = 9;
  - BONUS_PTS = 5;
  - SCORE_MAX = 99 (as two BCD constants).
- Sub-module bcd_digit_add: combinational, 4-bit digit + 4-bit addend + carry-in -> 4-bit digit + carry-out. Instantiated twice (ones, tens).
- The top level holds the FSM, the saturation/wrap logic, the ball counter and the frame-sync registers.

Test Plan:
- Reset then 3 hits, one frame_tick -> dig1:dig0 = 0:3 one cycle after the tick; outputs stay 0:0 before the tick.
- Score 0:7 plus a bonus, then a tick -> 1:2; score 0:9 with hit and bonus in the same cycle -> 1:5.
- SATURATE=1 at 9:8 with bonus -> 9:9, ovf = 0. SATURATE=0 at 9:8 with bonus -> 0:3, ovf high exactly one cycle.
- MAX_BALLS=3: three misses -> balls shows 2, 1, 0 after ticks; game_over asserts the cycle after the 3rd miss; subsequent hits leave the score unchanged.
- In OVER with score 4:2, assert clear together with hit -> state PLAY, working score 0:0 (the hit is dropped); display shows 4:2 until the next tick, then 0:0 with balls = 3.
- Hit coincident with frame_tick at score 0:0 -> display 0:0 after that tick, 0:1 after the next tick. Assert rst_n low mid-sequence -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg -- shared types and constants for the score_counter block
// Revision: 1.0
// ============================================================================
`default_nettype none

package score_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BONUS_PTS      = 4'd5;
  localparam logic [3:0] SCORE_MAX_TENS = 4'd9;
  localparam logic [3:0] SCORE_MAX_ONES = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// bcd_digit_add -- one BCD digit plus addend plus carry-in, with decimal carry
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic [3:0] addend_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] raw;

  assign raw = {1'b0, digit_i} + {1'b0, addend_i} + {4'd0, carry_i};

  // Subtracting 10 in 4-bit arithmetic is correct for every raw sum 10..16.
  always_comb begin
    sum_o   = raw[3:0];
    carry_o = 1'b0;
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum_o   = raw[3:0] - 4'd10;
      carry_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_counter.sv
// ============================================================================
// score_counter -- BCD score / ball bookkeeping with frame-synchronous display
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_counter
  import score_pkg::*;
#(
  parameter int MAX_BALLS = 3,
  parameter bit SATURATE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       bonus,
  input  logic       miss,
  input  logic       clear,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [2:0] balls,
  output logic       game_over,
  output logic       ovf
);

  localparam logic [2:0] BALLS_INIT = 3'(MAX_BALLS);

  state_e     state_q, state_d;
  logic [3:0] w0_q, w0_d, w1_q, w1_d;
  logic [2:0] wb_q, wb_d;
  logic       ovf_q, ovf_d;
  logic [3:0] dig0_q, dig1_q;
  logic [2:0] balls_q;

  logic [3:0] inc;
  logic [3:0] sum0, sum1;
  logic       carry0, carry1;

  assign inc = (hit ? 4'd1 : 4'd0) + (bonus ? BONUS_PTS : 4'd0);

  bcd_digit_add u_add_ones (
    .digit_i  (w0_q),
    .addend_i (inc),
    .carry_i  (1'b0),
    .sum_o    (sum0),
    .carry_o  (carry0)
  );

  bcd_digit_add u_add_tens (
    .digit_i  (w1_q),
    .addend_i (4'd0),
    .carry_i  (carry0),
    .sum_o    (sum1),
    .carry_o  (carry1)
  );

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    wb_d    = wb_q;
    ovf_d   = 1'b0;
    if (clear) begin
      state_d = ST_PLAY;
      w0_d    = 4'd0;
      w1_d    = 4'd0;
      wb_d    = BALLS_INIT;
    end else if (state_q == ST_PLAY) begin
      // A tens carry-out means the sum passed 99.
      if (carry1 && SATURATE) begin
        w1_d = SCORE_MAX_TENS;
        w0_d = SCORE_MAX_ONES;
      end else begin
        w1_d  = sum1;
        w0_d  = sum0;
        ovf_d = carry1;
      end
      if (miss) begin
        wb_d = wb_q - 3'd1;
        if (wb_q == 3'd1) begin
          state_d = ST_OVER;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PLAY;
      w0_q    <= 4'd0;
      w1_q    <= 4'd0;
      wb_q    <= BALLS_INIT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      wb_q    <= wb_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display only moves in vertical blanking so the overlay never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig0_q  <= 4'd0;
      dig1_q  <= 4'd0;
      balls_q <= BALLS_INIT;
    end else if (frame_tick) begin
      dig0_q  <= w0_q;
      dig1_q  <= w1_q;
      balls_q <= wb_q;
    end
  end

  assign dig0      = dig0_q;
  assign dig1      = dig1_q;
  assign balls     = balls_q;
  assign game_over = (state_q == ST_OVER);
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_score_counter.sv
// ============================================================================
// tb_score_counter -- directed bench for score_counter (saturating and wrapping)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_score_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, hit = 1'b0, bonus = 1'b0, miss = 1'b0, clear = 1'b0;

  logic [3:0] s_dig0, s_dig1, w_dig0, w_dig1;
  logic [2:0] s_balls, w_balls;
  logic       s_go, w_go, s_ovf, w_ovf;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  score_counter #(.MAX_BALLS(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit(hit), .bonus(bonus),
    .miss(miss), .clear(clear), .dig0(s_dig0), .dig1(s_dig1), .balls(s_balls),
    .game_over(s_go), .ovf(s_ovf)
  );

  score_counter #(.MAX_BALLS(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hit(hit), .bonus(bonus),
    .miss(miss), .clear(clear), .dig0(w_dig0), .dig1(w_dig1), .balls(w_balls),
    .game_over(w_go), .ovf(w_ovf)
  );

  typedef struct {
    logic       h, b, m, c, t;
    logic [3:0] e1, e0;
    logic [2:0] eb;
    logic       ego;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic h, logic b, logic m, logic c, logic t,
                              logic [3:0] e1, logic [3:0] e0, logic [2:0] eb, logic ego);
    vec_t v;
    v.h = h; v.b = b; v.m = m; v.c = c; v.t = t;
    v.e1 = e1; v.e0 = e0; v.eb = eb; v.ego = ego;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Checks both instances; the wrapping one may differ in digits and ovf.
  task automatic chk_out(input string name, input int e1, input int e0, input int eb,
                         input int ego, input int e1w, input int e0w, input int eovfw);
    chk({name, " sat.dig1"},  int'(s_dig1),  e1);
    chk({name, " sat.dig0"},  int'(s_dig0),  e0);
    chk({name, " sat.balls"}, int'(s_balls), eb);
    chk({name, " sat.go"},    int'(s_go),    ego);
    chk({name, " sat.ovf"},   int'(s_ovf),   0);
    chk({name, " wrap.dig1"}, int'(w_dig1),  e1w);
    chk({name, " wrap.dig0"}, int'(w_dig0),  e0w);
    chk({name, " wrap.balls"},int'(w_balls), eb);
    chk({name, " wrap.go"},   int'(w_go),    ego);
    chk({name, " wrap.ovf"},  int'(w_ovf),   eovfw);
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic cyc(input logic h, input logic b, input logic m, input logic c, input logic t);
    hit = h; bonus = b; miss = m; clear = c; frame_tick = t;
    @(posedge clk);
    #1;
    hit = 1'b0; bonus = 1'b0; miss = 1'b0; clear = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    // hit bonus miss clear tick | displayed dig1 dig0 balls game_over
    vecs[0]  = mk(1,0,0,0,0, 0,0,3,0);
    vecs[1]  = mk(1,0,0,0,0, 0,0,3,0);
    vecs[2]  = mk(1,0,0,0,0, 0,0,3,0);
    vecs[3]  = mk(0,0,0,0,1, 0,3,3,0);
    vecs[4]  = mk(1,0,0,0,0, 0,3,3,0);
    vecs[5]  = mk(1,0,0,0,0, 0,3,3,0);
    vecs[6]  = mk(1,0,0,0,0, 0,3,3,0);
    vecs[7]  = mk(1,0,0,0,0, 0,3,3,0);
    vecs[8]  = mk(0,1,0,0,0, 0,3,3,0);
    vecs[9]  = mk(0,0,0,0,1, 1,2,3,0);
    vecs[10] = mk(0,0,0,1,0, 1,2,3,0);
    vecs[11] = mk(0,1,0,0,0, 1,2,3,0);
    vecs[12] = mk(1,0,0,0,0, 1,2,3,0);
    vecs[13] = mk(1,0,0,0,0, 1,2,3,0);
    vecs[14] = mk(1,0,0,0,0, 1,2,3,0);
    vecs[15] = mk(1,0,0,0,0, 1,2,3,0);
    vecs[16] = mk(1,1,0,0,0, 1,2,3,0);
    vecs[17] = mk(0,0,0,0,1, 1,5,3,0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0,0,3,0, 0,0,0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].h, vecs[i].b, vecs[i].m, vecs[i].c, vecs[i].t);
      chk_out($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e0, vecs[i].eb, vecs[i].ego,
              vecs[i].e1, vecs[i].e0, 0);
    end

    // Build 98: 16 x (hit+bonus) = 96, then two hits.
    cyc(0,0,0,1,0);
    for (int i = 0; i < 16; i++) cyc(1,1,0,0,0);
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    cyc(0,0,0,0,1);
    chk_out("at98", 9,8,3,0, 9,8,0);
    cyc(0,1,0,0,0);
    chk_out("bonus98", 9,8,3,0, 9,8,1);
    cyc(0,0,0,0,0);
    chk_out("ovf_drop", 9,8,3,0, 9,8,0);
    cyc(0,0,0,0,1);
    chk_out("sat_vs_wrap", 9,9,3,0, 0,3,0);

    // Score 42, then lose all three balls.
    cyc(0,0,0,1,0);
    for (int i = 0; i < 7; i++) cyc(1,1,0,0,0);
    cyc(0,0,1,0,0);
    chk_out("miss1", 9,9,3,0, 0,3,0);
    cyc(0,0,0,0,1);
    chk_out("balls2", 4,2,2,0, 4,2,0);
    cyc(0,0,1,0,0);
    cyc(0,0,0,0,1);
    chk_out("balls1", 4,2,1,0, 4,2,0);
    cyc(0,0,1,0,0);
    chk_out("go_assert", 4,2,1,1, 4,2,0);
    cyc(0,0,0,0,1);
    chk_out("balls0", 4,2,0,1, 4,2,0);
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,0,0,1);
    chk_out("over_ignores", 4,2,0,1, 4,2,0);

    // clear beats a same-cycle hit; display waits for the tick.
    cyc(1,0,0,1,0);
    chk_out("clear_hit", 4,2,0,0, 4,2,0);
    cyc(0,0,0,0,1);
    chk_out("clear_tick", 0,0,3,0, 0,0,0);

    // Hit coincident with tick shows one frame later.
    cyc(1,0,0,0,1);
    chk_out("hit_on_tick", 0,0,3,0, 0,0,0);
    cyc(0,0,0,0,1);
    chk_out("next_tick", 0,1,3,0, 0,1,0);

    // Asynchronous reset mid-cycle.
    cyc(0,0,1,0,1);
    cyc(1,0,0,0,1);
    chk_out("pre_reset", 0,1,2,0, 0,1,0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0,0,3,0, 0,0,0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
